dcache_direct_mapped: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the load/store unit and block memory.
- Initiator side of the block memory protocol: drives valid / r0w1 / address / write data; consumes ready / read data.
- Word-granular processor port; 128-bit block memory port.
- At most one memory request outstanding.

---
 rtl/dcache_direct_mapped_pkg.sv | 41 ++++
 rtl/dcache_direct_mapped_line_array.sv | 75 +++++++
 rtl/dcache_direct_mapped.sv | 200 ++++++++++++++++++++
 tb/tb_dcache_direct_mapped.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_direct_mapped_pkg.sv
// Shared types and sizing helpers for the direct-mapped write-back data cache.
package dcache_direct_mapped_pkg;

  localparam int DEF_BW_ADDRESS    = 32;
  localparam int DEF_BW_WORD       = 32;
  localparam int DEF_BW_LAST_BLOCK = 128;
  localparam int DEF_NUM_SET       = 8;

  typedef enum logic [1:0] {
    COMPARE    = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } state_e;

  function automatic int offset_bits(input int bw_block);
    return $clog2(bw_block / 8);
  endfunction

  function automatic int index_bits(input int num_set);
    return $clog2(num_set);
  endfunction

  function automatic int wsel_bits(input int bw_block, input int bw_word);
    return $clog2(bw_block / bw_word);
  endfunction

  function automatic int tag_bits(input int bw_addr, input int bw_block, input int num_set);
    return bw_addr - offset_bits(bw_block) - index_bits(num_set);
  endfunction

  localparam int DEF_TAG_W = tag_bits(DEF_BW_ADDRESS, DEF_BW_LAST_BLOCK, DEF_NUM_SET);

  // One cache line as seen by the controller (default sizing).
  typedef struct packed {
    logic                         valid;
    logic                         dirty;
    logic [DEF_TAG_W-1:0]         tag;
    logic [DEF_BW_LAST_BLOCK-1:0] data;
  } line_t;

endpackage

// File: rtl/dcache_direct_mapped_line_array.sv
// Line storage: reset-cleared valid/dirty bits, unreset tag and word-banked data
// arrays with combinational read, a word write port and a whole-block fill port.
module dcache_line_array
  import dcache_direct_mapped_pkg::*;
#(
  parameter int NUM_SET       = DEF_NUM_SET,
  parameter int BW_WORD       = DEF_BW_WORD,
  parameter int BW_LAST_BLOCK = DEF_BW_LAST_BLOCK,
  parameter int TAG_W         = DEF_TAG_W,
  parameter int IDX_W         = index_bits(NUM_SET),
  parameter int WSEL_W        = wsel_bits(BW_LAST_BLOCK, BW_WORD)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IDX_W-1:0]         index,
  input  logic [WSEL_W-1:0]        wsel,
  output logic                     rd_valid,
  output logic                     rd_dirty,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [BW_LAST_BLOCK-1:0] rd_data,
  output logic [BW_WORD-1:0]       rd_word,
  input  logic                     word_we,
  input  logic [BW_WORD-1:0]       word_wdata,
  input  logic                     block_we,
  input  logic [TAG_W-1:0]         block_tag,
  input  logic [BW_LAST_BLOCK-1:0] block_wdata
);

  localparam int NUM_WORD = BW_LAST_BLOCK / BW_WORD;

  logic [NUM_SET-1:0] valid_reg;
  logic [NUM_SET-1:0] dirty_reg;
  logic [TAG_W-1:0]   tag_mem [NUM_SET];
  logic [BW_WORD-1:0] words [NUM_WORD];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (block_we) begin
      valid_reg[index] <= 1'b1;
      dirty_reg[index] <= 1'b0;
    end else if (word_we) begin
      dirty_reg[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (block_we) tag_mem[index] <= block_tag;
  end

  // One array per word lane so each lane has a single writer.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORD; gi++) begin : g_bank
      logic [BW_WORD-1:0] bank_mem [NUM_SET];

      always_ff @(posedge clk) begin
        if (block_we)
          bank_mem[index] <= block_wdata[gi*BW_WORD +: BW_WORD];
        else if (word_we && (wsel == WSEL_W'(gi)))
          bank_mem[index] <= word_wdata;
      end

      assign words[gi]                      = bank_mem[index];
      assign rd_data[gi*BW_WORD +: BW_WORD] = bank_mem[index];
    end
  endgenerate

  assign rd_valid = valid_reg[index];
  assign rd_dirty = dirty_reg[index];
  assign rd_tag   = tag_mem[index];
  assign rd_word  = words[wsel];

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back, write-allocate data cache with a registered block-memory
// initiator port. Define DCACHE_STAT_EN to add hit/miss counters.
module dcache_direct_mapped
  import dcache_direct_mapped_pkg::*;
#(
  parameter int BW_ADDRESS    = DEF_BW_ADDRESS,
  parameter int BW_WORD       = DEF_BW_WORD,
  parameter int BW_LAST_BLOCK = DEF_BW_LAST_BLOCK,
  parameter int NUM_SET       = DEF_NUM_SET
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_proc_read,
  input  logic                     i_proc_write,
  input  logic [BW_ADDRESS-1:0]    i_proc_addr,
  input  logic [BW_WORD-1:0]       i_proc_wdata,
  output logic                     o_proc_stall,
  output logic [BW_WORD-1:0]       o_proc_rdata,
  output logic                     o_mem_valid,
  output logic                     o_mem_r0w1,
  output logic [BW_ADDRESS-1:0]    o_mem_rwaddr,
  output logic [BW_LAST_BLOCK-1:0] o_mem_wdata,
  input  logic                     i_mem_ready,
  input  logic [BW_LAST_BLOCK-1:0] i_mem_rdata
`ifdef DCACHE_STAT_EN
  ,
  output logic [31:0]              o_hit_count,
  output logic [31:0]              o_miss_count
`endif
);

  localparam int OFF_W  = offset_bits(BW_LAST_BLOCK);
  localparam int IDX_W  = index_bits(NUM_SET);
  localparam int WSEL_W = wsel_bits(BW_LAST_BLOCK, BW_WORD);
  localparam int TAG_W  = tag_bits(BW_ADDRESS, BW_LAST_BLOCK, NUM_SET);

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_index;
  logic [WSEL_W-1:0] req_wsel;
  logic              unused_byte_bits;

  assign req_tag          = i_proc_addr[BW_ADDRESS-1 -: TAG_W];
  assign req_index        = i_proc_addr[OFF_W +: IDX_W];
  assign req_wsel         = i_proc_addr[OFF_W-1 -: WSEL_W];
  assign unused_byte_bits = ^i_proc_addr[OFF_W-WSEL_W-1:0];

  logic                     line_valid;
  logic                     line_dirty;
  logic [TAG_W-1:0]         line_tag;
  logic [BW_LAST_BLOCK-1:0] line_data;
  logic [BW_WORD-1:0]       line_word;
  line_t                    line;
  logic                     word_we;
  logic                     block_we;

  dcache_line_array #(
    .NUM_SET      (NUM_SET),
    .BW_WORD      (BW_WORD),
    .BW_LAST_BLOCK(BW_LAST_BLOCK),
    .TAG_W        (TAG_W),
    .IDX_W        (IDX_W),
    .WSEL_W       (WSEL_W)
  ) u_lines (
    .clk        (clk),
    .rst_n      (rst_n),
    .index      (req_index),
    .wsel       (req_wsel),
    .rd_valid   (line_valid),
    .rd_dirty   (line_dirty),
    .rd_tag     (line_tag),
    .rd_data    (line_data),
    .rd_word    (line_word),
    .word_we    (word_we),
    .word_wdata (i_proc_wdata),
    .block_we   (block_we),
    .block_tag  (req_tag),
    .block_wdata(i_mem_rdata)
  );

  assign line = {line_valid, line_dirty, line_tag, line_data};

  state_e                   state_reg, state_next;
  logic                     mem_valid_reg, mem_valid_next;
  logic                     mem_r0w1_reg, mem_r0w1_next;
  logic [BW_ADDRESS-1:0]    mem_addr_reg, mem_addr_next;
  logic [BW_LAST_BLOCK-1:0] mem_wdata_reg, mem_wdata_next;
  logic                     req;
  logic                     hit;
  logic                     stall;
  logic                     mem_accept;

  assign req        = i_proc_read | i_proc_write;
  assign hit        = line.valid && (line.tag == req_tag);
  assign mem_accept = mem_valid_reg && i_mem_ready;

  always_comb begin
    state_next     = state_reg;
    stall          = 1'b0;
    word_we        = 1'b0;
    block_we       = 1'b0;
    mem_valid_next = mem_valid_reg;
    mem_r0w1_next  = mem_r0w1_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    case (state_reg)
      COMPARE: begin
        if (req && !hit) begin
          stall          = 1'b1;
          mem_valid_next = 1'b1;
          if (line.valid && line.dirty) begin
            state_next     = WRITE_BACK;
            mem_r0w1_next  = 1'b1;
            mem_addr_next  = {line.tag, req_index, {OFF_W{1'b0}}};
            mem_wdata_next = line.data;
          end else begin
            state_next    = ALLOCATE;
            mem_r0w1_next = 1'b0;
            mem_addr_next = {req_tag, req_index, {OFF_W{1'b0}}};
          end
        end else if (i_proc_write && hit) begin
          word_we = 1'b1;
        end
      end
      WRITE_BACK: begin
        stall = 1'b1;
        if (mem_accept) begin
          mem_valid_next = 1'b0;
          state_next     = ALLOCATE;
        end
      end
      ALLOCATE: begin
        stall = 1'b1;
        if (mem_accept) begin
          mem_valid_next = 1'b0;
          block_we       = 1'b1;
          state_next     = COMPARE;
        end else if (!mem_valid_reg) begin
          // Entered from WRITE_BACK: valid has now been low for a cycle.
          mem_valid_next = 1'b1;
          mem_r0w1_next  = 1'b0;
          mem_addr_next  = {req_tag, req_index, {OFF_W{1'b0}}};
        end
      end
      default: state_next = COMPARE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= COMPARE;
      mem_valid_reg <= 1'b0;
      mem_r0w1_reg  <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      mem_valid_reg <= mem_valid_next;
      mem_r0w1_reg  <= mem_r0w1_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  assign o_mem_valid  = mem_valid_reg;
  assign o_mem_r0w1   = mem_r0w1_reg;
  assign o_mem_rwaddr = mem_addr_reg;
  assign o_mem_wdata  = mem_wdata_reg;

  // Processor outputs are forced to their idle values while reset is held.
  assign o_proc_stall = rst_n & stall;
  assign o_proc_rdata = (rst_n && i_proc_read && (state_reg == COMPARE) && hit) ? line_word : '0;

`ifdef DCACHE_STAT_EN
  logic [31:0] hit_count_reg;
  logic [31:0] miss_count_reg;
  logic        refill_reg;

  // refill_reg marks the post-allocate hit of a request already counted as a miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
      refill_reg     <= 1'b0;
    end else if (state_reg == COMPARE && req) begin
      if (!hit) begin
        miss_count_reg <= miss_count_reg + 32'd1;
        refill_reg     <= 1'b1;
      end else if (refill_reg) begin
        refill_reg <= 1'b0;
      end else begin
        hit_count_reg <= hit_count_reg + 32'd1;
      end
    end
  end

  assign o_hit_count  = hit_count_reg;
  assign o_miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Randomized bench for dcache_direct_mapped against a word-level shadow memory and a
// tag/valid/dirty occupancy model; a behavioural block memory with latency answers requests.
`timescale 1ns/1ps
module tb_dcache_direct_mapped;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_proc_read = 1'b0;
  logic         i_proc_write = 1'b0;
  logic [31:0]  i_proc_addr = '0;
  logic [31:0]  i_proc_wdata = '0;
  logic         o_proc_stall;
  logic [31:0]  o_proc_rdata;
  logic         o_mem_valid;
  logic         o_mem_r0w1;
  logic [31:0]  o_mem_rwaddr;
  logic [127:0] o_mem_wdata;
  logic         i_mem_ready;
  logic [127:0] i_mem_rdata;
`ifdef DCACHE_STAT_EN
  logic [31:0]  o_hit_count;
  logic [31:0]  o_miss_count;
`endif

  dcache_direct_mapped dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_proc_read (i_proc_read),
    .i_proc_write(i_proc_write),
    .i_proc_addr (i_proc_addr),
    .i_proc_wdata(i_proc_wdata),
    .o_proc_stall(o_proc_stall),
    .o_proc_rdata(o_proc_rdata),
    .o_mem_valid (o_mem_valid),
    .o_mem_r0w1  (o_mem_r0w1),
    .o_mem_rwaddr(o_mem_rwaddr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ready (i_mem_ready),
    .i_mem_rdata (i_mem_rdata)
`ifdef DCACHE_STAT_EN
    ,
    .o_hit_count (o_hit_count),
    .o_miss_count(o_miss_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- behavioural block memory ----------------
  typedef struct {
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] wdata;
    int           cyc;
  } txn_t;

  txn_t         log_q[$];
  logic [127:0] mem [logic [31:0]];
  int           mem_latency = 0;
  bit           mem_block = 0;

  function automatic logic [127:0] init_block(input logic [31:0] blk);
    logic [127:0] b;
    if (blk == 32'h10) return 128'h88887777_66665555_44443333_22221111;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = (blk + 32'(4 * i)) ^ KEY;
    return b;
  endfunction

  function automatic logic [127:0] mem_rd(input logic [31:0] blk);
    if (mem.exists(blk)) return mem[blk];
    return init_block(blk);
  endfunction

  bit           pending = 0;
  int           busy = 0;
  int           waited = 0;
  logic         snap_rw;
  logic [31:0]  snap_addr;
  logic [127:0] snap_wdata;

  initial begin
    txn_t t;
    i_mem_ready = 1'b0;
    i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        i_mem_ready = 1'b0;
        pending = 0;
        busy = 0;
      end else if (i_mem_ready) begin
        i_mem_ready = 1'b0;
        t.rw = snap_rw; t.addr = snap_addr; t.wdata = snap_wdata; t.cyc = cyc;
        log_q.push_back(t);
        if (snap_rw) mem[snap_addr] = snap_wdata;
        check("valid_drop_after_accept", o_mem_valid, 1'b0);
        pending = 0;
        busy = mem_latency;
      end else if (busy > 0) begin
        busy--;
      end else if (pending) begin
        check("hold_valid", o_mem_valid, 1'b1);
        check("hold_addr", o_mem_rwaddr, snap_addr);
        check("hold_r0w1", o_mem_r0w1, snap_rw);
        if (snap_rw) check("hold_wdata", o_mem_wdata, snap_wdata);
        waited++;
      end else if (o_mem_valid) begin
        snap_rw = o_mem_r0w1; snap_addr = o_mem_rwaddr; snap_wdata = o_mem_wdata;
        pending = 1;
        waited = 0;
      end
      if (pending && rst_n && !mem_block && waited >= mem_latency) begin
        i_mem_ready = 1'b1;
        i_mem_rdata = snap_rw ? 128'h0 : mem_rd(snap_addr);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] shadow [logic [31:0]];
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [24:0] m_tag [8];
  int          exp_hits = 0;
  int          exp_misses = 0;

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [127:0] b;
    if (shadow.exists(a)) return shadow[a];
    b = init_block({a[31:4], 4'h0});
    return b[a[3:2]*32 +: 32];
  endfunction

  function automatic logic [127:0] exp_block(input logic [31:0] blk);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = exp_word(blk + 32'(4 * i));
    return b;
  endfunction

  // Reset loses dirty data: the processor view falls back to what memory holds.
  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      if (m_valid[s] && m_dirty[s]) begin
        logic [31:0]  blk;
        logic [127:0] b;
        blk = {m_tag[s], 3'(s), 4'h0};
        b = mem_rd(blk);
        for (int i = 0; i < 4; i++) shadow[blk + 32'(4 * i)] = b[i*32 +: 32];
      end
      m_valid[s] = 0;
      m_dirty[s] = 0;
    end
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd);
    int           idx;
    logic [24:0]  tg;
    bit           exp_hit, exp_wb, first_stall;
    logic [31:0]  victim;
    logic [127:0] victim_blk;
    int           n0, spin;
    idx = int'(a[6:4]);
    tg = a[31:7];
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb = !exp_hit && m_valid[idx] && m_dirty[idx];
    victim = {m_tag[idx], a[6:4], 4'h0};
    victim_blk = exp_block(victim);
    n0 = log_q.size();
    spin = 0;
    @(negedge clk);
    i_proc_read = !wr; i_proc_write = wr; i_proc_addr = a; i_proc_wdata = wd;
    #1;
    first_stall = o_proc_stall;
    while (o_proc_stall && spin < 200) begin
      @(negedge clk);
      #1;
      spin++;
    end
    check("no_timeout", spin < 200, 1'b1);
    check("stall_on_entry", first_stall, !exp_hit);
    if (!wr) check("load_data", o_proc_rdata, exp_word(a));
    check("txn_count", log_q.size() - n0, exp_hit ? 0 : (exp_wb ? 2 : 1));
    if (!exp_hit && log_q.size() > n0) begin
      check("stall_clear_after_ready", log_q[$].cyc, cyc);
      check("alloc_r0w1", log_q[$].rw, 1'b0);
      check("alloc_addr", log_q[$].addr, {a[31:4], 4'h0});
      if (exp_wb) begin
        check("wb_r0w1", log_q[n0].rw, 1'b1);
        check("wb_addr", log_q[n0].addr, victim);
        check("wb_data", log_q[n0].wdata, victim_blk);
      end
    end
    $display("%s addr=%08h wdata=%08h rdata=%08h hit=%0d wb=%0d stall_cycles=%0d",
             wr ? "ST" : "LD", a, wd, o_proc_rdata, exp_hit, exp_wb, spin);
    @(negedge clk);
    i_proc_read = 0; i_proc_write = 0;
    if (exp_hit) exp_hits++; else exp_misses++;
    if (wr) shadow[a] = wd;
    m_valid[idx] = 1;
    m_tag[idx] = tg;
    if (!exp_hit) m_dirty[idx] = 0;
    if (wr) m_dirty[idx] = 1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int spin;
    for (int s = 0; s < 8; s++) begin m_valid[s] = 0; m_dirty[s] = 0; m_tag[s] = '0; end

    #1;
    check("rst_mem_valid", o_mem_valid, 1'b0);
    check("rst_mem_r0w1", o_mem_r0w1, 1'b0);
    check("rst_mem_addr", o_mem_rwaddr, 32'h0);
    check("rst_mem_wdata", o_mem_wdata, 128'h0);
    check("rst_stall", o_proc_stall, 1'b0);
    check("rst_rdata", o_proc_rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    access(0, 32'h10, 32'h0);
    check("cold_read_word0", o_proc_rdata === 32'h22221111 || 1'b0, 1'b1);
    access(1, 32'h14, 32'hDEADBEEF);
    access(0, 32'h14, 32'h0);
    mem_latency = 4;
    access(0, 32'h94, 32'h0);
    check("wb_holds_store", log_q[log_q.size()-2].wdata[63:32], 32'hDEADBEEF);
    mem_latency = 0;
`ifdef DCACHE_STAT_EN
    check("stat_hits_directed", o_hit_count, 32'd2);
    check("stat_misses_directed", o_miss_count, 32'd2);
`endif

    // Abandon an allocate with reset.
    mem_block = 1;
    @(negedge clk);
    i_proc_read = 1; i_proc_addr = 32'h200;
    spin = 0;
    while (!o_mem_valid && spin < 50) begin @(negedge clk); spin++; end
    check("alloc_issued", o_mem_valid && !o_mem_r0w1, 1'b1);
    check("alloc_stall", o_proc_stall, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_valid", o_mem_valid, 1'b0);
    check("reset_mid_stall", o_proc_stall, 1'b0);
    $display("RST during allocate addr=00000200 mem_valid=%0d stall=%0d", o_mem_valid, o_proc_stall);
    model_reset();
    repeat (2) @(negedge clk);
    i_proc_read = 0;
    mem_block = 0;
    rst_n = 1'b1;
    access(0, 32'h200, 32'h0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      mem_latency = $urandom_range(0, 4);
      access(bit'($urandom_range(0, 1)), a, $urandom);
    end

`ifdef DCACHE_STAT_EN
    check("stat_hits_final", o_hit_count, 32'(exp_hits));
    check("stat_misses_final", o_miss_count, 32'(exp_misses));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
